// File: rtl/regfile_wb_ctrl_pkg.sv
// Shared sizes and requester indices for the register-file write-back controller.
package regfile_wb_ctrl_pkg;

    // Register address and data sizes (x0..x31, 32-bit data).
    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;
    localparam int NREGS  = 32;

    // Write-back requester indices, also the encoding of the round-robin pointer.
    localparam logic WB_EXE = 1'b0;
    localparam logic WB_MEM = 1'b1;

endpackage

// File: rtl/regfile_wb_ctrl_if.sv
// Valid/ready write-back bus carrying both requesters (execute and memory).
interface regfile_wb_ctrl_if
    import regfile_wb_ctrl_pkg::*;
#(
    parameter int AW = ADDR_W,
    parameter int DW = DATA_W
);
    logic          wb0_valid;
    logic          wb0_ready;
    logic [AW-1:0] wb0_addr;
    logic [DW-1:0] wb0_data;
    logic          wb1_valid;
    logic          wb1_ready;
    logic [AW-1:0] wb1_addr;
    logic [DW-1:0] wb1_data;

    // Pipeline side: presents results, waits for ready.
    modport master (
        output wb0_valid, wb0_addr, wb0_data,
        output wb1_valid, wb1_addr, wb1_data,
        input  wb0_ready, wb1_ready
    );

    // Controller side: accepts results, returns ready.
    modport slave (
        input  wb0_valid, wb0_addr, wb0_data,
        input  wb1_valid, wb1_addr, wb1_data,
        output wb0_ready, wb1_ready
    );
endinterface

// File: rtl/regfile_wb_ctrl_scoreboard.sv
// Per-register busy mask: set on issue, cleared when the write commits.
module regfile_scoreboard
    import regfile_wb_ctrl_pkg::*;
#(
    parameter int AW = ADDR_W,
    parameter int NR = NREGS
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          set_en,
    input  logic [AW-1:0] set_addr,
    input  logic          clr_en,
    input  logic [AW-1:0] clr_addr,
    input  logic [AW-1:0] rs1_addr,
    input  logic [AW-1:0] rs2_addr,
    output logic          rs1_busy,
    output logic          rs2_busy,
    output logic          all_clear
);

    localparam logic [AW-1:0] ZERO_ADDR = {AW{1'b0}};

    logic [NR-1:0] busy_r;
    logic [NR-1:0] busy_next_s;

    // Next mask: clear first, then set so a newer in-flight writer wins; x0 never busy.
    always_comb begin
        busy_next_s = busy_r;
        if (clr_en && (clr_addr != ZERO_ADDR)) begin
            busy_next_s[clr_addr] = 1'b0;
        end else begin
            busy_next_s = busy_next_s;
        end
        if (set_en && (set_addr != ZERO_ADDR)) begin
            busy_next_s[set_addr] = 1'b1;
        end else begin
            busy_next_s = busy_next_s;
        end
        busy_next_s[0] = 1'b0;
    end

    // Busy mask register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            busy_r <= {NR{1'b0}};
        end else begin
            busy_r <= busy_next_s;
        end
    end

    // Operand lookups are combinational so decode stalls in the same cycle.
    assign rs1_busy  = busy_r[rs1_addr];
    assign rs2_busy  = busy_r[rs2_addr];
    assign all_clear = (busy_r == {NR{1'b0}});

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Arbitrates two write-back requesters onto the single register-file write port
// and tracks pending destination registers for decode stalls.
module regfile_wb_ctrl
    import regfile_wb_ctrl_pkg::*;
#(
    parameter int ADDR_W = regfile_wb_ctrl_pkg::ADDR_W,
    parameter int DATA_W = regfile_wb_ctrl_pkg::DATA_W,
    parameter int NREGS  = regfile_wb_ctrl_pkg::NREGS
) (
    input  logic                clk,
    input  logic                reset,
    regfile_wb_ctrl_if.slave    wb,
    input  logic                issue_valid,
    input  logic [ADDR_W-1:0]   issue_rd,
    input  logic [ADDR_W-1:0]   rs1_addr,
    input  logic [ADDR_W-1:0]   rs2_addr,
    output logic                rs1_busy,
    output logic                rs2_busy,
    output logic                wr_enable,
    output logic [ADDR_W-1:0]   wr_addr,
    output logic [DATA_W-1:0]   wr_data,
    output logic                idle
);

    localparam logic [ADDR_W-1:0] ZERO_ADDR = {ADDR_W{1'b0}};

    logic                rr_ptr_r;
    logic                gnt0_s;
    logic                gnt1_s;
    logic                contend_s;
    logic                wr_enable_r;
    logic [ADDR_W-1:0]   wr_addr_r;
    logic [DATA_W-1:0]   wr_data_r;
    logic                all_clear_s;

    assign contend_s = wb.wb0_valid && wb.wb1_valid;

    // Grant: lone requester wins outright, contention goes to rr_ptr; nothing during reset.
    always_comb begin
        gnt0_s = 1'b0;
        gnt1_s = 1'b0;
        if (!reset) begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
        end else if (contend_s) begin
            gnt0_s = (rr_ptr_r == WB_EXE);
            gnt1_s = (rr_ptr_r == WB_MEM);
        end else begin
            gnt0_s = wb.wb0_valid;
            gnt1_s = wb.wb1_valid;
        end
    end

    assign wb.wb0_ready = gnt0_s;
    assign wb.wb1_ready = gnt1_s;

    // Round-robin pointer and the registered write port; x0 writes are accepted but dropped.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rr_ptr_r    <= WB_EXE;
            wr_enable_r <= 1'b0;
            wr_addr_r   <= ZERO_ADDR;
            wr_data_r   <= {DATA_W{1'b0}};
        end else begin
            if (contend_s) begin
                rr_ptr_r <= ~rr_ptr_r;
            end else begin
                rr_ptr_r <= rr_ptr_r;
            end
            if (gnt0_s) begin
                wr_enable_r <= (wb.wb0_addr != ZERO_ADDR);
                wr_addr_r   <= wb.wb0_addr;
                wr_data_r   <= wb.wb0_data;
            end else if (gnt1_s) begin
                wr_enable_r <= (wb.wb1_addr != ZERO_ADDR);
                wr_addr_r   <= wb.wb1_addr;
                wr_data_r   <= wb.wb1_data;
            end else begin
                wr_enable_r <= 1'b0;
            end
        end
    end

    regfile_scoreboard #(
        .AW (ADDR_W),
        .NR (NREGS)
    ) u_scoreboard (
        .clk       (clk),
        .reset     (reset),
        .set_en    (issue_valid),
        .set_addr  (issue_rd),
        .clr_en    (wr_enable_r),
        .clr_addr  (wr_addr_r),
        .rs1_addr  (rs1_addr),
        .rs2_addr  (rs2_addr),
        .rs1_busy  (rs1_busy),
        .rs2_busy  (rs2_busy),
        .all_clear (all_clear_s)
    );

    assign wr_enable = wr_enable_r;
    assign wr_addr   = wr_addr_r;
    assign wr_data   = wr_data_r;
    assign idle      = all_clear_s && !wr_enable_r;

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Directed bench for regfile_wb_ctrl: reset, single write, contention, x0 drop,
// scoreboard set/clear priority, reset mid-operation and back-to-back writes.
module tb_regfile_wb_ctrl;
    import regfile_wb_ctrl_pkg::*;

    logic              clk;
    logic              reset;
    logic              issue_valid;
    logic [ADDR_W-1:0] issue_rd;
    logic [ADDR_W-1:0] rs1_addr;
    logic [ADDR_W-1:0] rs2_addr;
    logic              rs1_busy;
    logic              rs2_busy;
    logic              wr_enable;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              idle;

    int vec_cnt;
    int err_cnt;

    regfile_wb_ctrl_if wb_bus ();

    regfile_wb_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .wb          (wb_bus.slave),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .rs1_addr    (rs1_addr),
        .rs2_addr    (rs2_addr),
        .rs1_busy    (rs1_busy),
        .rs2_busy    (rs2_busy),
        .wr_enable   (wr_enable),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .idle        (idle)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance to 1 ns after the next rising edge; inputs are driven from here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        wb_bus.wb0_valid = 1'b1;
        wb_bus.wb0_addr  = 5'd1;
        wb_bus.wb0_data  = 32'h0000_0011;
        rs1_addr = 5'd5;
        for (int i = 0; i < 2; i++) begin
            tick();
            #1;
            vec_cnt++;
            if (wb_bus.wb0_ready !== 1'b0) begin
                err_cnt++;
                $display("FAIL reset_ready got %b exp 0", wb_bus.wb0_ready);
            end
        end
        vec_cnt++;
        if (wr_enable !== 1'b0) begin
            err_cnt++;
            $display("FAIL reset_wr_enable got %b exp 0", wr_enable);
        end
        vec_cnt++;
        if (wr_addr !== 5'd0 || wr_data !== 32'd0) begin
            err_cnt++;
            $display("FAIL reset_wr_port got %0d/%h exp 0/0", wr_addr, wr_data);
        end
        vec_cnt++;
        if (rs1_busy !== 1'b0) begin
            err_cnt++;
            $display("FAIL reset_rs1_busy got %b exp 0", rs1_busy);
        end
        vec_cnt++;
        if (idle !== 1'b1) begin
            err_cnt++;
            $display("FAIL reset_idle got %b exp 1", idle);
        end
        reset = 1'b1;
        #1;
        vec_cnt++;
        if (wb_bus.wb0_ready !== 1'b1) begin
            err_cnt++;
            $display("FAIL release_ready got %b exp 1", wb_bus.wb0_ready);
        end
        wb_bus.wb0_valid = 1'b0;
        tick();
    endtask

    task automatic test_single_write();
        wb_bus.wb0_valid = 1'b1;
        wb_bus.wb0_addr  = 5'd5;
        wb_bus.wb0_data  = 32'hDEAD_BEEF;
        #1;
        vec_cnt++;
        if (wb_bus.wb0_ready !== 1'b1 || wb_bus.wb1_ready !== 1'b0) begin
            err_cnt++;
            $display("FAIL single_ready got %b%b exp 10", wb_bus.wb0_ready, wb_bus.wb1_ready);
        end
        tick();
        wb_bus.wb0_valid = 1'b0;
        vec_cnt++;
        if (wr_enable !== 1'b1 || wr_addr !== 5'd5 || wr_data !== 32'hDEAD_BEEF) begin
            err_cnt++;
            $display("FAIL single_write got en=%b a=%0d d=%h exp en=1 a=5 d=deadbeef",
                     wr_enable, wr_addr, wr_data);
        end
        tick();
        vec_cnt++;
        if (wr_enable !== 1'b0 || wr_addr !== 5'd5 || wr_data !== 32'hDEAD_BEEF) begin
            err_cnt++;
            $display("FAIL single_hold got en=%b a=%0d d=%h exp en=0 a=5 d=deadbeef",
                     wr_enable, wr_addr, wr_data);
        end
    endtask

    task automatic test_contention();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        wb_bus.wb0_valid = 1'b1;
        wb_bus.wb0_addr  = 5'd3;
        wb_bus.wb0_data  = 32'hA0A0_0003;
        wb_bus.wb1_valid = 1'b1;
        wb_bus.wb1_addr  = 5'd4;
        wb_bus.wb1_data  = 32'hB0B0_0004;
        for (int i = 0; i < 4; i++) begin
            #1;
            vec_cnt++;
            if (wb_bus.wb0_ready !== (i % 2 == 0) || wb_bus.wb1_ready !== (i % 2 == 1)) begin
                err_cnt++;
                $display("FAIL contend_grant[%0d] got r0=%b r1=%b exp r0=%b r1=%b", i,
                         wb_bus.wb0_ready, wb_bus.wb1_ready, (i % 2 == 0), (i % 2 == 1));
            end
            tick();
            vec_cnt++;
            if (wr_enable !== 1'b1 || wr_addr !== ((i % 2 == 0) ? 5'd3 : 5'd4)) begin
                err_cnt++;
                $display("FAIL contend_write[%0d] got en=%b a=%0d exp en=1 a=%0d", i,
                         wr_enable, wr_addr, (i % 2 == 0) ? 3 : 4);
            end
        end
        wb_bus.wb0_valid = 1'b0;
        wb_bus.wb1_valid = 1'b0;
        tick();
    endtask

    task automatic test_x0_drop();
        wb_bus.wb1_valid = 1'b1;
        wb_bus.wb1_addr  = 5'd0;
        wb_bus.wb1_data  = 32'h0000_1234;
        #1;
        vec_cnt++;
        if (wb_bus.wb1_ready !== 1'b1 || wb_bus.wb0_ready !== 1'b0) begin
            err_cnt++;
            $display("FAIL x0_ready got r0=%b r1=%b exp r0=0 r1=1", wb_bus.wb0_ready, wb_bus.wb1_ready);
        end
        tick();
        wb_bus.wb1_valid = 1'b0;
        vec_cnt++;
        if (wr_enable !== 1'b0) begin
            err_cnt++;
            $display("FAIL x0_wr_enable got %b exp 0", wr_enable);
        end
        issue_valid = 1'b1;
        issue_rd    = 5'd0;
        rs1_addr    = 5'd0;
        tick();
        issue_valid = 1'b0;
        #1;
        vec_cnt++;
        if (rs1_busy !== 1'b0 || idle !== 1'b1) begin
            err_cnt++;
            $display("FAIL x0_issue got busy=%b idle=%b exp busy=0 idle=1", rs1_busy, idle);
        end
    endtask

    task automatic test_scoreboard();
        issue_valid = 1'b1;
        issue_rd    = 5'd7;
        tick();
        issue_valid = 1'b0;
        rs1_addr    = 5'd7;
        rs2_addr    = 5'd8;
        #1;
        vec_cnt++;
        if (rs1_busy !== 1'b1 || rs2_busy !== 1'b0 || idle !== 1'b0) begin
            err_cnt++;
            $display("FAIL sb_set got b1=%b b2=%b idle=%b exp 1 0 0", rs1_busy, rs2_busy, idle);
        end
        wb_bus.wb0_valid = 1'b1;
        wb_bus.wb0_addr  = 5'd7;
        wb_bus.wb0_data  = 32'h0000_0077;
        tick();
        wb_bus.wb0_valid = 1'b0;
        vec_cnt++;
        if (wr_enable !== 1'b1 || rs1_busy !== 1'b1) begin
            err_cnt++;
            $display("FAIL sb_write_cycle got en=%b busy=%b exp en=1 busy=1", wr_enable, rs1_busy);
        end
        tick();
        vec_cnt++;
        if (rs1_busy !== 1'b0 || wr_enable !== 1'b0 || idle !== 1'b1) begin
            err_cnt++;
            $display("FAIL sb_clear got busy=%b en=%b idle=%b exp 0 0 1", rs1_busy, wr_enable, idle);
        end
        // Re-issue 7, write it back, and re-issue 7 on the commit edge.
        issue_valid = 1'b1;
        issue_rd    = 5'd7;
        tick();
        issue_valid = 1'b0;
        wb_bus.wb0_valid = 1'b1;
        wb_bus.wb0_data  = 32'h0000_0777;
        tick();
        wb_bus.wb0_valid = 1'b0;
        issue_valid = 1'b1;
        issue_rd    = 5'd7;
        tick();
        issue_valid = 1'b0;
        vec_cnt++;
        if (rs1_busy !== 1'b1) begin
            err_cnt++;
            $display("FAIL sb_set_wins got %b exp 1", rs1_busy);
        end
        issue_valid = 1'b1;
        issue_rd    = 5'd12;
        rs2_addr    = 5'd12;
        tick();
        issue_valid = 1'b0;
        vec_cnt++;
        if (rs2_busy !== 1'b1 || rs1_busy !== 1'b1) begin
            err_cnt++;
            $display("FAIL sb_two_regs got b1=%b b2=%b exp 1 1", rs1_busy, rs2_busy);
        end
    endtask

    task automatic test_reset_midop();
        issue_valid = 1'b1;
        issue_rd    = 5'd9;
        tick();
        issue_valid = 1'b0;
        wb_bus.wb0_valid = 1'b1;
        wb_bus.wb0_addr  = 5'd9;
        wb_bus.wb0_data  = 32'h0000_0099;
        rs2_addr = 5'd9;
        tick();
        vec_cnt++;
        if (wr_enable !== 1'b1 || rs2_busy !== 1'b1) begin
            err_cnt++;
            $display("FAIL midop_pre got en=%b busy=%b exp 1 1", wr_enable, rs2_busy);
        end
        wb_bus.wb0_addr = 5'd10;
        reset = 1'b0;
        #1;
        vec_cnt++;
        if (wb_bus.wb0_ready !== 1'b0) begin
            err_cnt++;
            $display("FAIL midop_ready got %b exp 0", wb_bus.wb0_ready);
        end
        tick();
        wb_bus.wb0_valid = 1'b0;
        vec_cnt++;
        if (wr_enable !== 1'b0 || rs2_busy !== 1'b0 || rs1_busy !== 1'b0 || idle !== 1'b1) begin
            err_cnt++;
            $display("FAIL midop_reset got en=%b b2=%b b1=%b idle=%b exp 0 0 0 1",
                     wr_enable, rs2_busy, rs1_busy, idle);
        end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_back_to_back();
        wb_bus.wb0_valid = 1'b1;
        wb_bus.wb0_addr  = 5'd10;
        wb_bus.wb0_data  = 32'h1111_0010;
        tick();
        wb_bus.wb0_valid = 1'b0;
        wb_bus.wb1_valid = 1'b1;
        wb_bus.wb1_addr  = 5'd11;
        wb_bus.wb1_data  = 32'h2222_0011;
        vec_cnt++;
        if (wr_enable !== 1'b1 || wr_addr !== 5'd10 || wr_data !== 32'h1111_0010) begin
            err_cnt++;
            $display("FAIL b2b_first got en=%b a=%0d d=%h exp 1 10 11110010", wr_enable, wr_addr, wr_data);
        end
        tick();
        wb_bus.wb1_valid = 1'b0;
        vec_cnt++;
        if (wr_enable !== 1'b1 || wr_addr !== 5'd11 || wr_data !== 32'h2222_0011) begin
            err_cnt++;
            $display("FAIL b2b_second got en=%b a=%0d d=%h exp 1 11 22220011", wr_enable, wr_addr, wr_data);
        end
        tick();
        vec_cnt++;
        if (wr_enable !== 1'b0 || idle !== 1'b1) begin
            err_cnt++;
            $display("FAIL b2b_done got en=%b idle=%b exp 0 1", wr_enable, idle);
        end
    endtask

    initial begin
        vec_cnt = 0;
        err_cnt = 0;
        reset = 1'b0;
        issue_valid = 1'b0;
        issue_rd = 5'd0;
        rs1_addr = 5'd0;
        rs2_addr = 5'd0;
        wb_bus.wb0_valid = 1'b0;
        wb_bus.wb0_addr  = 5'd0;
        wb_bus.wb0_data  = 32'd0;
        wb_bus.wb1_valid = 1'b0;
        wb_bus.wb1_addr  = 5'd0;
        wb_bus.wb1_data  = 32'd0;
        #1;
        test_reset();
        test_single_write();
        test_contention();
        test_x0_drop();
        test_scoreboard();
        test_reset_midop();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/regfile_wb_ctrl.md
Name: regfile_wb_ctrl

Overview:
Write-back controller for the integer register file. It shares the file's single write port between two write-back requesters: requester 0 is the ALU/execute stage and requester 1 is the load/memory stage. It also keeps a per-register busy scoreboard so the decode stage can stall on source operands whose write is still in flight. It sits between the pipeline write-back sources and the register file write port, and drives that port's address, data and enable directly.

Parameters:
ADDR_W, 5, register address width; matches the shared register-address size define (4:0).
DATA_W, 32, register data width; matches the shared register-data size define (31:0).
NREGS, 32, number of architectural registers; x0 is hardwired to zero.

Ports:
clk  in  1  single clock; all state updates on posedge.
reset  in  1  synchronous, active-low reset; sampled at posedge clk; 0 = reset.
wb0_valid  in  1  requester 0 (execute) has a result.
wb0_ready  out  1  requester 0 transfer accepted this cycle.
wb0_addr  in  ADDR_W  destination register for requester 0.
wb0_data  in  DATA_W  result from requester 0.
wb1_valid  in  1  requester 1 (load) has a result.
wb1_ready  out  1  requester 1 transfer accepted this cycle.
wb1_addr  in  ADDR_W  destination register for requester 1.
wb1_data  in  DATA_W  result from requester 1.
issue_valid  in  1  decode issues an instruction that writes issue_rd.
issue_rd  in  ADDR_W  destination register of the issued instruction.
rs1_addr  in  ADDR_W  decode source operand 1.
rs2_addr  in  ADDR_W  decode source operand 2.
rs1_busy  out  1  write to rs1_addr still pending.
rs2_busy  out  1  write to rs2_addr still pending.
wr_enable  out  1  register file write enable (registered).
wr_addr  out  ADDR_W  register file write address (registered).
wr_data  out  DATA_W  register file write data (registered).
idle  out  1  no busy registers and no write in flight.

Behaviour:
- Reset (reset==0 at posedge):
  - wr_enable=0, wr_addr=0, wr_data=0.
  - rr_ptr=0, busy mask all 0.
  - wb0_ready and wb1_ready are forced to 0 combinationally while reset==0.
- Handshake:
  - A transfer occurs on requester i when wbi_valid && wbi_ready.
  - The requester holds valid, addr and data stable until it sees ready.
  - wbi_ready is combinational from the valids and rr_ptr, and never depends on wbi_ready itself.
- Arbitration:
  - Only one valid: that requester is granted the same cycle.
  - Both valid: grant requester rr_ptr, then flip rr_ptr at posedge.
  - rr_ptr updates only on a contended grant.
  - At most one ready is high per cycle.
- Write port timing:
  - On a transfer at posedge N, the controller drives wr_enable=1, wr_addr and wr_data during cycle N+1.
  - Latency is one cycle.
  - A transfer to address 0 is accepted (ready=1) but produces wr_enable=0, so the write is dropped.
  - With no transfer, wr_enable=0; wr_addr and wr_data hold their last value.
- Scoreboard:
  - busy[NREGS-1:1] is a register mask; busy[0] is constant 0.
  - Set: issue_valid && issue_rd!=0 sets busy[issue_rd] at posedge.
  - Clear: at a posedge where wr_enable==1, busy[wr_addr] is cleared. This is the same edge the register file captures the data, so a source seen as non-busy reads the new value on the following read.
  - Set and clear of the same address on the same edge: set wins, because a newer writer is now in flight.
  - Re-issue to an already busy register: busy stays 1. There is no per-register count; in-order write-back is required of the pipeline.
- rs1_busy = busy[rs1_addr] and rs2_busy = busy[rs2_addr], both combinational. Address 0 always returns 0.
- idle = (busy==0) && !wr_enable.
- Reset mid-operation:
  - A pending wb*_valid is not accepted; ready stays 0 during reset.
  - An in-flight wr_enable is cleared; that write is lost.
  - The scoreboard is cleared.

Decomposition:
- Shared parameter file: register address/data size defines, NREGS, and requester index constants (WB_EXE=0, WB_MEM=1).
- Sub-module regfile_scoreboard holds the busy mask, set/clear/priority logic, the two lookup ports and the all-clear flag.
- Arbiter and write-port register stay in regfile_wb_ctrl.

Test Plan:
- Reset: hold reset=0 for 2 cycles with wb0_valid=1 → wb0_ready=0, wr_enable=0, rs1_busy=0, idle=1. Release → wb0_ready=1 in the same cycle.
- Single write: wb0 valid with addr=5, data=0xDEADBEEF at cycle N → cycle N+1 drives wr_enable=1, wr_addr=5, wr_data=0xDEADBEEF; cycle N+2 wr_enable=0.
- Contention: both valid for 4 cycles, wb0 addr=3, wb1 addr=4, from reset → grants go wb0, wb1, wb0, wb1; never both ready.
- x0 drop: wb1 valid with addr=0, data=0x1234 → wb1_ready=1, next cycle wr_enable=0. issue_rd=0 leaves rs1_busy=0 for rs1_addr=0.
- Scoreboard: issue rd=7 → rs1_busy=1 for rs1_addr=7. Transfer to addr 7 → busy remains 1 through the write cycle, drops the cycle after wr_enable. Issue rd=7 on the same edge the write to 7 commits → rs1_busy stays 1.
- Reset mid-op: busy[9]=1 and wr_enable=1, then assert reset → next cycle wr_enable=0, rs2_busy(9)=0, idle=1.
